// File: rtl/aes_pkg.sv
// Shared AES-128 types, FSM encoding, Rcon table and round-function helpers.
// Used by the S-box leaf and by the encrypt core.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;

  typedef logic [127:0] aes_state_t;
  typedef logic [31:0]  aes_word_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } aes_fsm_e;

  // Rcon[1] in the top byte down to Rcon[10] in the bottom byte.
  localparam logic [79:0] RCON_TABLE = 80'h01_02_04_08_10_20_40_80_1b_36;

  function automatic logic [7:0] rcon(input logic [3:0] round);
    if (round == 4'd0 || round > 4'(NUM_ROUNDS)) return 8'h00;
    return RCON_TABLE[8*(NUM_ROUNDS - int'(round)) +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic aes_word_t rot_word(input aes_word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  // Byte s[r][c] lives at [127-8*(4c+r) -: 8]; row r rotates left by r columns.
  function automatic aes_state_t shift_rows(input aes_state_t s);
    aes_state_t o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic aes_word_t mix_column(input aes_word_t w);
    logic [7:0] a0, a1, a2, a3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic aes_state_t mix_columns(input aes_state_t s);
    aes_state_t o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  // sub_rot is SubWord(RotWord(w3)) of the current round key.
  function automatic aes_state_t next_round_key(input aes_state_t rk,
                                                input aes_word_t  sub_rot,
                                                input logic [7:0] rc);
    aes_word_t w0, w1, w2, w3;
    w0 = rk[127:96] ^ sub_rot ^ {rc, 24'h000000};
    w1 = rk[95:64] ^ w0;
    w2 = rk[63:32] ^ w1;
    w3 = rk[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Entry 0x00 occupies the top byte; entry 0xff the bottom byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_byte = SBOX_TABLE[8*(255 - int'(in_byte)) +: 8];

endmodule

// File: rtl/aes_encrypt_core.sv
// Iterative AES-128 encryptor with on-the-fly key expansion and valid/ready handshakes.
// Optional debug taps (round_tap, round_idx) are enabled by defining AES_ENC_ROUND_TAP_EN.
module aes_encrypt_core
  import aes_pkg::*;
#(
  parameter int SBOX_REG = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
`ifdef AES_ENC_ROUND_TAP_EN
  ,
  output logic [127:0] round_tap,
  output logic [3:0]   round_idx
`endif
);

  aes_fsm_e   fsm_q, fsm_d;
  aes_state_t state_q, state_d;
  aes_state_t rk_q, rk_d;
  logic [3:0] rcnt_q, rcnt_d;
  logic       out_valid_q, out_valid_d;
  logic       phase_q, phase_d;

  logic       accept;
  logic       round_step;
  aes_state_t sb_d, sb_use;
  aes_word_t  ksb_in, ksb_d, ksb_use;
  aes_state_t mix_st, round_st, rk_next;

  // 16 S-boxes for SubBytes on the state, 4 for SubWord in the key schedule.
  for (genvar i = 0; i < 16; i++) begin : g_state_sbox
    aes_sbox u_sbox (
      .in_byte (state_q[8*i +: 8]),
      .out_byte(sb_d[8*i +: 8])
    );
  end

  assign ksb_in = rot_word(rk_q[31:0]);

  for (genvar i = 0; i < 4; i++) begin : g_key_sbox
    aes_sbox u_sbox (
      .in_byte (ksb_in[8*i +: 8]),
      .out_byte(ksb_d[8*i +: 8])
    );
  end

  if (SBOX_REG != 0) begin : g_sbox_reg
    aes_state_t sb_q;
    aes_word_t  ksb_q;

    // NOTE: pure pipeline stage, always written in phase 0 before being read in phase 1, so no reset.
    always_ff @(posedge clk) begin
      sb_q  <= sb_d;
      ksb_q <= ksb_d;
    end

    assign sb_use     = sb_q;
    assign ksb_use    = ksb_q;
    assign round_step = phase_q;
  end else begin : g_sbox_comb
    assign sb_use     = sb_d;
    assign ksb_use    = ksb_d;
    assign round_step = 1'b1;
  end

  // Round datapath: ShiftRows, MixColumns except in the last round, AddRoundKey.
  always_comb begin
    rk_next = next_round_key(rk_q, ksb_use, rcon(rcnt_q));
    mix_st  = shift_rows(sb_use);
    if (rcnt_q != 4'(NUM_ROUNDS)) begin
      mix_st = mix_columns(mix_st);
    end
    round_st = mix_st ^ rk_next;
  end

  assign in_ready = (fsm_q == ST_IDLE) || ((fsm_q == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    // NOTE: every _d defaults to its _q so no branch can leave it unassigned and infer a latch.
    fsm_d       = fsm_q;
    state_d     = state_q;
    rk_d        = rk_q;
    rcnt_d      = rcnt_q;
    out_valid_d = out_valid_q;
    phase_d     = phase_q;

    if (accept) begin
      fsm_d       = ST_RUN;
      state_d     = in_data ^ in_key;
      rk_d        = in_key;
      rcnt_d      = 4'd1;
      out_valid_d = 1'b0;
      phase_d     = 1'b0;
    end else begin
      case (fsm_q)
        ST_RUN: begin
          phase_d = (SBOX_REG != 0) ? ~phase_q : 1'b0;
          if (round_step) begin
            state_d = round_st;
            rk_d    = rk_next;
            if (rcnt_q == 4'(NUM_ROUNDS)) begin
              fsm_d       = ST_DONE;
              out_valid_d = 1'b1;
            end else begin
              rcnt_d = rcnt_q + 4'd1;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            fsm_d       = ST_IDLE;
            rcnt_d      = 4'd0;
            out_valid_d = 1'b0;
          end
        end
        default: begin
          fsm_d  = ST_IDLE;
          rcnt_d = 4'd0;
        end
      endcase
    end
  end

  // NOTE: non-blocking assignments so every flop updates from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= ST_IDLE;
      state_q     <= '0;
      rk_q        <= '0;
      rcnt_q      <= 4'd0;
      out_valid_q <= 1'b0;
      phase_q     <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      rk_q        <= rk_d;
      rcnt_q      <= rcnt_d;
      out_valid_q <= out_valid_d;
      phase_q     <= phase_d;
    end
  end

  // The state register holds the ciphertext after the last round, until the next accept.
  assign out_valid = out_valid_q;
  assign out_data  = state_q;

`ifdef AES_ENC_ROUND_TAP_EN
  assign round_tap = state_q;
  assign round_idx = rcnt_q;
`endif

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Directed scoreboard bench for aes_encrypt_core: FIPS-197 vectors, hold, back-to-back,
// mid-run reset, and the SBOX_REG=1 build; round taps checked when AES_ENC_ROUND_TAP_EN is set.
`timescale 1ns/1ps
module tb_aes_encrypt_core;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] TAP0_B = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] TAP1_B = 128'ha49c7ff2689f352b6b5bea43026a5049;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   in_valid, in_ready, out_valid, out_ready;
  logic [127:0] in_data [2];
  logic [127:0] in_key  [2];
  logic [127:0] out_data[2];
`ifdef AES_ENC_ROUND_TAP_EN
  logic [127:0] round_tap[2];
  logic [3:0]   round_idx[2];
`endif

  logic [127:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  aes_encrypt_core #(.SBOX_REG(0)) dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid[0]),
    .in_ready (in_ready[0]),
    .in_data  (in_data[0]),
    .in_key   (in_key[0]),
    .out_valid(out_valid[0]),
    .out_ready(out_ready[0]),
    .out_data (out_data[0])
`ifdef AES_ENC_ROUND_TAP_EN
    ,
    .round_tap(round_tap[0]),
    .round_idx(round_idx[0])
`endif
  );

  aes_encrypt_core #(.SBOX_REG(1)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid[1]),
    .in_ready (in_ready[1]),
    .in_data  (in_data[1]),
    .in_key   (in_key[1]),
    .out_valid(out_valid[1]),
    .out_ready(out_ready[1]),
    .out_data (out_data[1])
`ifdef AES_ENC_ROUND_TAP_EN
    ,
    .round_tap(round_tap[1]),
    .round_idx(round_idx[1])
`endif
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a block, wait (bounded) for acceptance, then scramble the inputs.
  task automatic send(input int d, input logic [127:0] pt, input logic [127:0] key,
                      input logic [127:0] exp);
    int n;
    n = 0;
    in_data[d]  = pt;
    in_key[d]   = key;
    in_valid[d] = 1'b1;
    while (!in_ready[d] && n < 50) begin
      tick();
      n++;
    end
    check("in_ready_before_accept", 128'(in_ready[d]), 128'(1));
    tick();
    in_valid[d] = 1'b0;
    in_data[d]  = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_key[d]   = ~key;
    exp_q.push_back(exp);
  endtask

  // Count edges until out_valid, then compare latency and data against the scoreboard.
  task automatic wait_out(input int d, input int lat, input string tag);
    int n;
    logic [127:0] exp;
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid[d] && n < 100);
    check({tag, "_latency"}, 128'(n), 128'(lat));
    if (exp_q.size() == 0) exp = '0;
    else exp = exp_q.pop_front();
    check({tag, "_data"}, out_data[d], exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int b_lat;

    rst_n       = 1'b0;
    in_valid    = 2'b00;
    out_ready   = 2'b11;
    in_data[0]  = '0;
    in_data[1]  = '0;
    in_key[0]   = '0;
    in_key[1]   = '0;
    #2;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_data0", out_data[0], '0);
    check("rst_out_data1", out_data[1], '0);
    check("rst_in_ready", 128'(in_ready), 128'(2'b11));
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", 128'(in_ready), 128'(2'b11));
    check("idle_out_valid", 128'(out_valid), 128'(0));

    // FIPS-197 C.1, one round per cycle.
    send(0, PT_C1, KEY_C1, CT_C1);
    wait_out(0, 10, "c1");
    tick();
    check("c1_release_out_valid", 128'(out_valid[0]), 128'(0));
    check("c1_release_in_ready", 128'(in_ready[0]), 128'(1));

    // FIPS-197 B with out_ready held low for 5 cycles in DONE.
    out_ready[0] = 1'b0;
    send(0, PT_B, KEY_B, CT_B);
    b_lat = 10;
`ifdef AES_ENC_ROUND_TAP_EN
    check("b_tap_accept", round_tap[0], TAP0_B);
    check("b_idx_accept", 128'(round_idx[0]), 128'(1));
    tick();
    b_lat = 9;
    check("b_tap_round1", round_tap[0], TAP1_B);
    check("b_idx_round1", 128'(round_idx[0]), 128'(2));
`endif
    wait_out(0, b_lat, "b");
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_out_valid", 128'(out_valid[0]), 128'(1));
      check("hold_out_data", out_data[0], CT_B);
      check("hold_in_ready", 128'(in_ready[0]), 128'(0));
    end
    out_ready[0] = 1'b1;
    #1;
    check("release_in_ready", 128'(in_ready[0]), 128'(1));
    tick();
    check("release_out_valid", 128'(out_valid[0]), 128'(0));
    tick();
    check("single_handshake", 128'(out_valid[0]), 128'(0));

    // Back-to-back: in_valid held through RUN; B is accepted on the C.1 handshake edge.
    in_data[0]  = PT_C1;
    in_key[0]   = KEY_C1;
    in_valid[0] = 1'b1;
    tick();
    exp_q.push_back(CT_C1);
    in_data[0] = PT_B;
    in_key[0]  = KEY_B;
    check("b2b_run_in_ready", 128'(in_ready[0]), 128'(0));
    wait_out(0, 10, "b2b_first");
    check("b2b_done_in_ready", 128'(in_ready[0]), 128'(1));
    exp_q.push_back(CT_B);
    tick();
    in_valid[0] = 1'b0;
    check("b2b_no_bubble_out_valid", 128'(out_valid[0]), 128'(0));
    check("b2b_no_bubble_in_ready", 128'(in_ready[0]), 128'(0));
    wait_out(0, 10, "b2b_second");
    tick();
    check("b2b_release", 128'(out_valid[0]), 128'(0));

    // Reset asserted around round 5 discards the block in flight.
    send(0, PT_C1, KEY_C1, CT_C1);
    repeat (4) tick();
    rst_n = 1'b0;
    #2;
    check("midrst_out_valid", 128'(out_valid[0]), 128'(0));
    check("midrst_in_ready", 128'(in_ready[0]), 128'(1));
`ifdef AES_ENC_ROUND_TAP_EN
    check("midrst_round_idx", 128'(round_idx[0]), 128'(0));
`endif
    rst_n = 1'b1;
    void'(exp_q.pop_back());
    seen = 0;
    repeat (15) begin
      tick();
      if (out_valid[0]) seen++;
    end
    check("midrst_no_pulse", 128'(seen), 128'(0));
    send(0, PT_B, KEY_B, CT_B);
    wait_out(0, 10, "after_rst");
    tick();

    // SBOX_REG=1: same ciphertexts, two cycles per round.
    send(1, PT_C1, KEY_C1, CT_C1);
    wait_out(1, 20, "sr1_c1");
    tick();
    check("sr1_release", 128'(out_valid[1]), 128'(0));
    send(1, PT_B, KEY_B, CT_B);
    wait_out(1, 20, "sr1_b");
    tick();
    check("scoreboard_empty", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
